// File: rtl/eth_pkt_fifo.sv
// eth_pkt_fifo: single-clock packet FIFO. Frames are written word by word and
// become visible to the reader only when their last word is accepted. A frame
// can be abandoned with drop_i. A frame that hits a full FIFO is discarded up to
// its last word, and overflow_o then pulses.
module eth_pkt_fifo #(
   parameter int unsigned SLOTS     = 16,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned AFULL_THR = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   write_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   last_i,
   input  logic                   drop_i,
   input  logic                   read_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   last_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic                   afull_o,
   output logic [$clog2(SLOTS):0] ocup_o,
   output logic [$clog2(SLOTS):0] free_o,
   output logic [$clog2(SLOTS):0] pkt_cnt_o,
   output logic                   overflow_o,
   output logic                   error_o
);

   localparam int unsigned   AW       = $clog2(SLOTS);
   localparam int unsigned   PW       = AW + 1;
   localparam logic [PW-1:0] SLOTS_V  = PW'(SLOTS);
   // free_o never exceeds SLOTS, so a threshold at or above it means always almost-full
   localparam bit            THR_ALL  = (AFULL_THR >= SLOTS);
   localparam logic [PW-1:0] THR_V    = THR_ALL ? SLOTS_V : PW'(AFULL_THR);

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_FRAME,
      WR_DISCARD
   } wr_state_t;

   logic [WIDTH:0]  mem [SLOTS];

   wr_state_t       state, state_n;
   logic [PW-1:0]   wr_ptr, wr_ptr_n;
   logic [PW-1:0]   commit_ptr, commit_n;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   pkt_cnt;
   logic            overflow_q, ovf_n;

   logic            wr_en;
   logic            commit_inc;
   logic            pop;
   logic            pop_last;
   logic [WIDTH:0]  head;
   logic [PW-1:0]   ocup;

   // Occupancy flags, head-of-queue view and access-error detection
   always_comb begin
      ocup       = wr_ptr - rd_ptr;
      head       = mem[rd_ptr[AW-1:0]];
      empty_o    = (commit_ptr == rd_ptr);
      full_o     = (ocup == SLOTS_V);
      ocup_o     = ocup;
      free_o     = SLOTS_V - ocup;
      afull_o    = THR_ALL || (free_o <= THR_V);
      data_o     = empty_o ? '0 : head[WIDTH-1:0];
      last_o     = empty_o ? 1'b0 : head[WIDTH];
      pkt_cnt_o  = pkt_cnt;
      overflow_o = overflow_q;
      error_o    = (read_i && empty_o) || (write_i && full_o);
      pop        = read_i && !empty_o;
      pop_last   = pop && head[WIDTH];
   end

   // Write-side FSM: accept, commit, drop or discard the frame being written
   always_comb begin
      state_n    = state;
      wr_ptr_n   = wr_ptr;
      commit_n   = commit_ptr;
      ovf_n      = 1'b0;
      wr_en      = 1'b0;
      commit_inc = 1'b0;
      unique case (state)
         WR_IDLE, WR_FRAME: begin
            if (drop_i) begin
               wr_ptr_n = commit_ptr;
               state_n  = WR_IDLE;
            end else if (write_i && full_o) begin
               // the word is lost; rewind to the last committed boundary
               wr_ptr_n = commit_ptr;
               if (last_i) begin
                  ovf_n   = 1'b1;
                  state_n = WR_IDLE;
               end else begin
                  state_n = WR_DISCARD;
               end
            end else if (write_i) begin
               wr_en    = 1'b1;
               wr_ptr_n = wr_ptr + PW'(1);
               if (last_i) begin
                  commit_n   = wr_ptr + PW'(1);
                  commit_inc = 1'b1;
                  state_n    = WR_IDLE;
               end else begin
                  state_n = WR_FRAME;
               end
            end
         end
         WR_DISCARD: begin
            if (drop_i) begin
               state_n = WR_IDLE;
            end else if (write_i && last_i) begin
               ovf_n   = 1'b1;
               state_n = WR_IDLE;
            end
         end
         default: begin
            state_n = WR_IDLE;
         end
      endcase
   end

   // State, pointers, frame count and overflow pulse; clear_i overrides all traffic
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= WR_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         overflow_q <= 1'b0;
      end else if (clear_i) begin
         state      <= WR_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_n;
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_n;
         overflow_q <= ovf_n;
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         // a commit and a last-word pop in the same cycle cancel out
         unique case ({commit_inc, pop_last})
            2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   // Storage array, written only on accepted words and never reset
   always_ff @(posedge clk) begin
      if (wr_en && !clear_i) begin
         mem[wr_ptr[AW-1:0]] <= {last_i, data_i};
      end
   end

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// tb_eth_pkt_fifo: table vectors, directed corner sequences and random traffic
// for eth_pkt_fifo, checked against a queue-based frame model.
module tb_eth_pkt_fifo;

   localparam int unsigned SLOTS = 16;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned THR   = 4;
   localparam int unsigned PW    = $clog2(SLOTS) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear_i, write_i, last_i, drop_i, read_i;
   logic [WIDTH-1:0] data_i;
   logic [WIDTH-1:0] data_o;
   logic             last_o, empty_o, full_o, afull_o, overflow_o, error_o;
   logic [PW-1:0]    ocup_o, free_o, pkt_cnt_o;

   always #5 clk = ~clk;

   eth_pkt_fifo #(.SLOTS(SLOTS), .WIDTH(WIDTH), .AFULL_THR(THR)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_i),
      .write_i    (write_i),
      .data_i     (data_i),
      .last_i     (last_i),
      .drop_i     (drop_i),
      .read_i     (read_i),
      .data_o     (data_o),
      .last_o     (last_o),
      .empty_o    (empty_o),
      .full_o     (full_o),
      .afull_o    (afull_o),
      .ocup_o     (ocup_o),
      .free_o     (free_o),
      .pkt_cnt_o  (pkt_cnt_o),
      .overflow_o (overflow_o),
      .error_o    (error_o)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: every stored word in order, the first ncommit are readable
   logic [WIDTH:0] store [$];
   int             ncommit     = 0;
   bit             discarding  = 1'b0;
   bit             ovf_exp     = 1'b0;

   typedef struct {
      bit               clr, wr, lst, drp, rd;
      logic [WIDTH-1:0] d;
      bit               e_empty;
      int               e_ocup;
      int               e_pkt;
      logic [WIDTH-1:0] e_data;
      bit               e_err;
      bit               e_ovf;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_pkts();
      int n = 0;
      for (int i = 0; i < ncommit; i++) begin
         if (store[i][WIDTH]) n++;
      end
      return n;
   endfunction

   function automatic void model_reset();
      store.delete();
      ncommit    = 0;
      discarding = 1'b0;
      ovf_exp    = 1'b0;
   endfunction

   function automatic void drop_pending();
      while (store.size() > ncommit) void'(store.pop_back());
   endfunction

   task automatic check_model();
      int             sz;
      int             fr;
      bit             emp;
      logic [WIDTH:0] hd;
      sz  = store.size();
      fr  = SLOTS - sz;
      emp = (ncommit == 0);
      hd  = emp ? '0 : store[0];
      chk("empty",    64'(empty_o),    64'(emp));
      chk("full",     64'(full_o),     64'(sz == SLOTS));
      chk("afull",    64'(afull_o),    64'(fr <= THR));
      chk("ocup",     64'(ocup_o),     64'(sz));
      chk("free",     64'(free_o),     64'(fr));
      chk("pkt_cnt",  64'(pkt_cnt_o),  64'(model_pkts()));
      chk("data",     64'(data_o),     64'(hd[WIDTH-1:0]));
      chk("last",     64'(last_o),     64'(hd[WIDTH]));
      chk("error",    64'(error_o),    64'((read_i && emp) || (write_i && sz == SLOTS)));
      chk("overflow", 64'(overflow_o), 64'(ovf_exp));
   endtask

   task automatic model_step();
      bit full_pre, emp_pre, pop;
      if (clear_i) begin
         model_reset();
         return;
      end
      full_pre = (store.size() == SLOTS);
      emp_pre  = (ncommit == 0);
      pop      = read_i && !emp_pre;
      ovf_exp  = 1'b0;
      if (!discarding) begin
         if (drop_i) begin
            drop_pending();
         end else if (write_i && full_pre) begin
            drop_pending();
            if (last_i) ovf_exp = 1'b1;
            else        discarding = 1'b1;
         end else if (write_i) begin
            store.push_back({last_i, data_i});
            if (last_i) ncommit = store.size();
         end
      end else begin
         if (drop_i) begin
            discarding = 1'b0;
         end else if (write_i && last_i) begin
            ovf_exp    = 1'b1;
            discarding = 1'b0;
         end
      end
      if (pop) begin
         void'(store.pop_front());
         ncommit--;
      end
   endtask

   task automatic drive(input bit clr, input bit wr, input bit lst, input bit drp,
                        input bit rd, input logic [WIDTH-1:0] d);
      clear_i = clr;
      write_i = wr;
      last_i  = lst;
      drop_i  = drp;
      read_i  = rd;
      data_i  = d;
   endtask

   task automatic finish_cycle();
      check_model();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit clr, input bit wr, input bit lst, input bit drp,
                        input bit rd, input logic [WIDTH-1:0] d);
      drive(clr, wr, lst, drp, rd, d);
      @(negedge clk);
      finish_cycle();
   endtask

   function automatic void add(bit clr, bit wr, bit lst, bit drp, bit rd, logic [WIDTH-1:0] d,
                               bit ee, int eo, int ep, logic [WIDTH-1:0] ed, bit er, bit ev);
      vec_t v;
      v.clr = clr; v.wr = wr; v.lst = lst; v.drp = drp; v.rd = rd; v.d = d;
      v.e_empty = ee; v.e_ocup = eo; v.e_pkt = ep; v.e_data = ed; v.e_err = er; v.e_ovf = ev;
      tbl.push_back(v);
   endfunction

   // Bound on total run time
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] wa, wb, wc, wd, we, wf, wg, wh, wi, wj;
      wa = 32'hA000_0001; wb = 32'hB000_0002; wc = 32'hC000_0003; wd = 32'hD000_0004;
      we = 32'hE000_0005; wf = 32'hF000_0006; wg = 32'h1111_0007; wh = 32'h2222_0008;
      wi = 32'h3333_0009; wj = 32'h4444_000A;

      //   clr wr lst drp rd data | empty ocup pkt data err ovf
      add(0, 0, 0, 0, 0, '0,  1, 0, 0, '0, 0, 0);
      add(0, 1, 0, 0, 0, wa,  1, 0, 0, '0, 0, 0);
      add(0, 1, 0, 0, 0, wb,  1, 1, 0, '0, 0, 0);
      add(0, 1, 1, 0, 0, wc,  1, 2, 0, '0, 0, 0);
      add(0, 0, 0, 0, 0, '0,  0, 3, 1, wa, 0, 0);
      add(0, 1, 0, 0, 0, wd,  0, 3, 1, wa, 0, 0);
      add(0, 1, 0, 0, 0, we,  0, 4, 1, wa, 0, 0);
      add(0, 1, 0, 1, 0, wf,  0, 5, 1, wa, 0, 0);
      add(0, 0, 0, 0, 0, '0,  0, 3, 1, wa, 0, 0);
      add(0, 0, 0, 0, 1, '0,  0, 3, 1, wa, 0, 0);
      add(0, 0, 0, 0, 1, '0,  0, 2, 1, wb, 0, 0);
      add(0, 0, 0, 0, 1, '0,  0, 1, 1, wc, 0, 0);
      add(0, 0, 0, 0, 1, '0,  1, 0, 0, '0, 1, 0);
      add(0, 0, 0, 0, 0, '0,  1, 0, 0, '0, 0, 0);
      add(0, 1, 0, 0, 0, wg,  1, 0, 0, '0, 0, 0);
      add(0, 1, 0, 0, 0, wh,  1, 1, 0, '0, 0, 0);
      add(0, 0, 0, 1, 0, '0,  1, 2, 0, '0, 0, 0);
      add(0, 0, 0, 0, 0, '0,  1, 0, 0, '0, 0, 0);
      add(0, 1, 1, 0, 0, wi,  1, 0, 0, '0, 0, 0);
      add(1, 1, 1, 0, 1, wj,  0, 1, 1, wi, 0, 0);
      add(0, 0, 0, 0, 0, '0,  1, 0, 0, '0, 0, 0);

      // reset values while reset is held
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, '0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_model();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // table vectors
      foreach (tbl[i]) begin
         drive(tbl[i].clr, tbl[i].wr, tbl[i].lst, tbl[i].drp, tbl[i].rd, tbl[i].d);
         @(negedge clk);
         chk($sformatf("tbl%0d.empty", i), 64'(empty_o),   64'(tbl[i].e_empty));
         chk($sformatf("tbl%0d.ocup", i),  64'(ocup_o),    64'(tbl[i].e_ocup));
         chk($sformatf("tbl%0d.pkt", i),   64'(pkt_cnt_o), 64'(tbl[i].e_pkt));
         chk($sformatf("tbl%0d.data", i),  64'(data_o),    64'(tbl[i].e_data));
         chk($sformatf("tbl%0d.err", i),   64'(error_o),   64'(tbl[i].e_err));
         chk($sformatf("tbl%0d.ovf", i),   64'(overflow_o), 64'(tbl[i].e_ovf));
         finish_cycle();
      end

      // 20-word frame into an empty FIFO with no reads
      for (int i = 1; i <= 20; i++) begin
         drive(0, 1, (i == 20), 0, 0, WIDTH'(i));
         @(negedge clk);
         if (i == 16) begin
            chk("ovr.w16_full", 64'(full_o), 64'(0));
            chk("ovr.w16_ocup", 64'(ocup_o), 64'(15));
         end
         if (i == 17) begin
            chk("ovr.w17_full",  64'(full_o),  64'(1));
            chk("ovr.w17_error", 64'(error_o), 64'(1));
         end
         if (i == 18) begin
            chk("ovr.w18_ocup",  64'(ocup_o),  64'(0));
            chk("ovr.w18_error", 64'(error_o), 64'(0));
         end
         if (i == 20) chk("ovr.w20_ovf", 64'(overflow_o), 64'(0));
         finish_cycle();
      end
      drive(0, 0, 0, 0, 0, '0);
      @(negedge clk);
      chk("ovr.pulse",      64'(overflow_o), 64'(1));
      chk("ovr.ocup",       64'(ocup_o),     64'(0));
      chk("ovr.empty",      64'(empty_o),    64'(1));
      finish_cycle();
      drive(0, 0, 0, 0, 0, '0);
      @(negedge clk);
      chk("ovr.pulse_end",  64'(overflow_o), 64'(0));
      finish_cycle();

      // pop a 1-word frame while committing a second frame
      cycle(0, 1, 1, 0, 0, 32'h0000_0C01);
      cycle(0, 1, 0, 0, 0, 32'h0000_0C02);
      drive(0, 1, 1, 0, 1, 32'h0000_0C03);
      @(negedge clk);
      chk("same.pre_data", 64'(data_o),    64'(32'h0000_0C01));
      chk("same.pre_pkt",  64'(pkt_cnt_o), 64'(1));
      finish_cycle();
      drive(0, 0, 0, 0, 0, '0);
      @(negedge clk);
      chk("same.pkt",  64'(pkt_cnt_o), 64'(1));
      chk("same.data", 64'(data_o),    64'(32'h0000_0C02));
      chk("same.ocup", 64'(ocup_o),    64'(2));
      finish_cycle();
      cycle(0, 0, 0, 0, 1, '0);
      cycle(0, 0, 0, 0, 1, '0);

      // push pointers past 2*SLOTS, then fill to 14 words and clear
      cycle(0, 1, 1, 0, 0, 32'h5000_0000);
      for (int i = 1; i < 40; i++) cycle(0, 1, 1, 0, 1, 32'h5000_0000 + WIDTH'(i));
      cycle(0, 0, 0, 0, 1, '0);
      for (int i = 1; i <= 14; i++) begin
         drive(0, 1, (i == 14), 0, 0, 32'h6000_0000 + WIDTH'(i));
         @(negedge clk);
         if (i == 12) begin
            chk("wrap.free5",  64'(free_o),  64'(5));
            chk("wrap.afull0", 64'(afull_o), 64'(0));
         end
         if (i == 13) begin
            chk("wrap.free4",  64'(free_o),  64'(4));
            chk("wrap.afull1", 64'(afull_o), 64'(1));
         end
         finish_cycle();
      end
      drive(0, 0, 0, 0, 0, '0);
      @(negedge clk);
      chk("wrap.ocup14", 64'(ocup_o),  64'(14));
      chk("wrap.afull",  64'(afull_o), 64'(1));
      chk("wrap.data",   64'(data_o),  64'(32'h6000_0001));
      finish_cycle();
      cycle(1, 0, 0, 0, 0, '0);
      drive(0, 0, 0, 0, 0, '0);
      @(negedge clk);
      chk("clr.empty", 64'(empty_o), 64'(1));
      chk("clr.free",  64'(free_o),  64'(16));
      chk("clr.pkt",   64'(pkt_cnt_o), 64'(0));
      finish_cycle();

      // asynchronous reset in the middle of a frame
      cycle(0, 1, 0, 0, 0, 32'h7000_0001);
      cycle(0, 1, 1, 0, 0, 32'h7000_0002);
      cycle(0, 1, 0, 0, 0, 32'h7000_0003);
      cycle(0, 1, 0, 0, 0, 32'h7000_0004);
      drive(0, 0, 0, 0, 0, '0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      chk("arst.empty", 64'(empty_o),    64'(1));
      chk("arst.full",  64'(full_o),     64'(0));
      chk("arst.afull", 64'(afull_o),    64'(0));
      chk("arst.ocup",  64'(ocup_o),     64'(0));
      chk("arst.free",  64'(free_o),     64'(16));
      chk("arst.pkt",   64'(pkt_cnt_o),  64'(0));
      chk("arst.data",  64'(data_o),     64'(0));
      chk("arst.last",  64'(last_o),     64'(0));
      chk("arst.error", 64'(error_o),    64'(0));
      chk("arst.ovf",   64'(overflow_o), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle(0, 0, 0, 0, 0, '0);

      // random traffic, read pressure alternating between light and heavy
      for (int seg = 0; seg < 6; seg++) begin
         int unsigned rd_pct;
         rd_pct = (seg % 2 == 0) ? 20 : 65;
         for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < rd_pct,
                  $urandom());
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/eth_pkt_fifo.md
ETH_PKT_FIFO -- requirements
Module: eth_pkt_fifo

Interface
REQ-001 Parameter SLOTS, default 16, FIFO depth in words; SHALL be a power of 2 and >= 2.
REQ-002 Parameter WIDTH, default 32, data word width in bits.
REQ-003 Parameter AFULL_THR, default 12, free-slot count at or below which afull_o asserts.
REQ-004 Single clock domain; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 clear_i  in  1  synchronous flush of all contents and state.
REQ-008 write_i  in  1  write strobe; data_i  in  WIDTH  write word; last_i  in  1  word ends frame.
REQ-009 drop_i  in  1  discard the frame currently being written.
REQ-010 read_i  in  1  read strobe (pop).
REQ-011 data_o  out  WIDTH  head word; last_o  out  1  head word ends frame.
REQ-012 empty_o  out  1  no committed word available; full_o  out  1  no free slot; afull_o  out  1  free_o <= AFULL_THR.
REQ-013 ocup_o, free_o  out  $clog2(SLOTS)+1  occupied/free slots including uncommitted words.
REQ-014 pkt_cnt_o  out  $clog2(SLOTS)+1  number of complete committed frames stored.
REQ-015 overflow_o  out  1  one-cycle pulse: frame discarded because of overflow.
REQ-016 error_o  out  1  read_i while empty_o, or write_i while full_o.

Function
REQ-017 Storage: SLOTS entries of WIDTH+1 bits (data plus last flag); pointers wr_ptr, commit_ptr, rd_ptr, each $clog2(SLOTS)+1 bits, wrapping modulo 2*SLOTS.
REQ-018 full_o = (wr_ptr - rd_ptr) == SLOTS; empty_o = (commit_ptr == rd_ptr); ocup_o = wr_ptr - rd_ptr; free_o = SLOTS - ocup_o; all combinational.
REQ-019 data_o/last_o are first-word-fall-through from entry rd_ptr; both 0 when empty_o.
REQ-020 Write FSM states WR_IDLE, WR_FRAME, WR_DISCARD.
REQ-021 Accepted write (write_i, !full_o, !drop_i, state != WR_DISCARD): store {last_i,data_i} at wr_ptr, wr_ptr+1; last_i=1 -> commit_ptr <= wr_ptr+1, pkt_cnt+1, next WR_IDLE; last_i=0 -> WR_FRAME.
REQ-022 drop_i in WR_IDLE/WR_FRAME: wr_ptr <= commit_ptr, write_i same cycle ignored, next WR_IDLE; no overflow_o.
REQ-023 write_i while full_o in WR_IDLE/WR_FRAME: word lost, wr_ptr <= commit_ptr; last_i=1 -> overflow_o pulse, stay WR_IDLE; else -> WR_DISCARD.
REQ-024 WR_DISCARD: all writes ignored; write_i with last_i=1 -> overflow_o pulse next cycle, WR_IDLE; drop_i -> WR_IDLE without pulse.
REQ-025 Read: read_i && !empty_o -> rd_ptr+1; if popped word has last=1, pkt_cnt-1.
REQ-026 Commit and last-word pop in same cycle: pkt_cnt unchanged; write and read same cycle both take effect.
REQ-027 Uncommitted words never visible on read side; empty_o stays 1 until commit.
REQ-028 error_o combinational, no state change caused by erroneous access.
REQ-029 clear_i: all pointers and pkt_cnt to 0, FSM to WR_IDLE, overflow_o 0 next cycle; overrides all same-cycle writes/reads.

Reset
REQ-030 rst low asynchronously sets pointers, pkt_cnt, FSM (WR_IDLE), overflow_o to 0; storage not reset.
REQ-031 During/after reset: empty_o=1, full_o=0, afull_o=0, ocup_o=0, free_o=SLOTS, pkt_cnt_o=0, data_o=0, last_o=0, error_o=0 absent strobes.
REQ-032 Reset asserted mid-frame discards uncommitted and committed data; no overflow_o pulse.

Verification
REQ-033 SLOTS=16: write 3 words (A,B,C, last on C) -> empty_o=1 until cycle after C, then data_o=A, pkt_cnt_o=1, ocup_o=3.
REQ-034 Write 2 words, assert drop_i -> ocup_o returns to prior value, empty_o stays 1, pkt_cnt_o=0, overflow_o=0.
REQ-035 Write 20-word frame, no reads -> full_o at 16, error_o on word 17, overflow_o one pulse after word 20, ocup_o=0.
REQ-036 One committed frame of 1 word; pop it while committing a second frame same cycle -> pkt_cnt_o stays 1, data_o = second frame's first word.
REQ-037 Fill to 14 words with pointers wrapped past 2*SLOTS -> afull_o=1 at free_o=4 (AFULL_THR=4 run), clear_i -> empty_o=1, free_o=16.
REQ-038 rst low asynchronously mid-frame -> all outputs at REQ-031 values before next clk edge.
